mul_16bit_arbiter: RTL and testbench
====================================

Name: mul_16bit_arbiter

Overview:
Shares one 16-bit Wallace tree multiplier (mul_16bit_wallace) between NUM_REQ requesters. Each requester uses a valid/ready request and response handshake. Arbitration is round-robin. The block sequences the multiplier by holding its active-low reset for one cycle while operands are loaded, then releasing it to start the multiply. It waits for o_end, guards against a hung multiplier with a timeout, and returns the 32-bit result plus carry to the winning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, operand width; result is 2*DATA_WIDTH
TIMEOUT_CYCLES, 64, maximum RUN cycles before an error response

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_req_vld  input  NUM_REQ  per-requester request valid
o_req_rdy  output  NUM_REQ  per-requester request ready (one-hot or zero)
i_req_num_x  input  NUM_REQ*DATA_WIDTH  packed operand X; requester k uses bits [k*DW +: DW]
i_req_num_y  input  NUM_REQ*DATA_WIDTH  packed operand Y, same packing as X
o_rsp_vld  output  NUM_REQ  per-requester response valid (one-hot or zero)
i_rsp_rdy  input  NUM_REQ  per-requester response ready
o_rsp_res  output  2*DATA_WIDTH  result, shared by all requesters
o_rsp_cry  output  1  carry from the multiplier
o_rsp_err  output  1  timeout flag; result forced to 0
o_busy  output  1  high whenever state is not IDLE
o_mul_rst_n  output  1  drives multiplier i_rst_n
o_mul_num_x  output  DATA_WIDTH  drives multiplier i_num_x
o_mul_num_y  output  DATA_WIDTH  drives multiplier i_num_y
i_mul_end  input  1  multiplier o_end
i_mul_res  input  2*DATA_WIDTH  multiplier o_res
i_mul_cry  input  1  multiplier o_cry

Behaviour:
- Reset (i_rst=1 at an edge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - All o_req_rdy, o_rsp_vld, o_rsp_res, o_rsp_cry, o_rsp_err, o_busy = 0.
  - o_mul_rst_n=0; operand registers=0.
  - Reset mid-operation aborts it: no response is issued and the multiplier is held in reset.
- States: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - Winner = first asserted i_req_vld searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - o_req_rdy[winner]=1 combinationally; all other bits 0.
  - Accept on vld&rdy: latch X/Y, grant index, rr_ptr<=winner; go to LOAD.
  - No valid requests: stay in IDLE.
- LOAD: exactly 1 cycle. o_mul_rst_n=0, latched operands driven. Go to RUN.
- RUN:
  - o_mul_rst_n=1 and timeout counter increments.
  - If i_mul_end=1: capture i_mul_res and i_mul_cry, err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: res=0, cry=0, err=1, go to RESP.
  - If end and timeout coincide, end wins.
- RESP:
  - o_rsp_vld[grant]=1 with registered res/cry/err held stable.
  - On i_rsp_rdy[grant]=1: go to IDLE.
  - i_rsp_rdy on other bits is ignored.
  - o_mul_rst_n stays 1 so the multiplier outputs remain stable.
- IDLE after RESP:
  - o_mul_rst_n=0.
  - A new request is accepted no earlier than the cycle after the response handshake; o_req_rdy is never high outside IDLE.
- Timing:
  - Request accepted at edge t; LOAD during t..t+1; o_mul_rst_n rises at t+1.
  - If the multiplier asserts end L cycles after reset release, o_rsp_vld rises one cycle after end is sampled.
  - Throughput is at most one operation per L+3 cycles.
- The controller does no arithmetic: result/cry pass through unchanged (signedness is the multiplier's).
- Requests dropped (vld deasserted) before grant are not serviced. Operands need only be stable in the accept cycle.

Test Plan:
- Single request: req 0 X=0xFFFA Y=0xFFF9, behavioural mul latency 3 -> one LOAD cycle with mul_rst_n=0, then o_rsp_vld[0] with res=0x0000002A, err=0; o_busy drops after rsp_rdy.
- Signed-mixed: req 2 X=0xFFFA Y=0x0005 -> o_rsp_vld=4'b0100, res=0xFFFFFFE2; other rsp_vld bits stay 0.
- Round-robin: all 4 requests held valid from reset -> grant order 0,1,2,3,0; each response carries its own operands' product.
- Response backpressure: hold i_rsp_rdy low 5 cycles -> o_rsp_vld and res stay stable; o_req_rdy=0 throughout; no new grant until the handshake.
- Timeout: model never asserts end -> after 64 RUN cycles, rsp with err=1, res=0; next request is serviced normally.
- Reset mid-RUN: assert i_rst in RUN -> next cycle IDLE, no rsp_vld, mul_rst_n=0, rr_ptr reset so requester 0 wins next.

Source files
------------

// File: rtl/mul_16bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_16bit_arbiter
// Purpose  : Round-robin sharing of one Wallace multiplier across requesters.
// Revision : 1.0 - initial release
// ============================================================================
module mul_16bit_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_vld,
    output logic [NUM_REQ-1:0]            o_req_rdy,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_num_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_num_y,
    output logic [NUM_REQ-1:0]            o_rsp_vld,
    input  logic [NUM_REQ-1:0]            i_rsp_rdy,
    output logic [2*DATA_WIDTH-1:0]       o_rsp_res,
    output logic                          o_rsp_cry,
    output logic                          o_rsp_err,
    output logic                          o_busy,
    output logic                          o_mul_rst_n,
    output logic [DATA_WIDTH-1:0]         o_mul_num_x,
    output logic [DATA_WIDTH-1:0]         o_mul_num_y,
    input  logic                          i_mul_end,
    input  logic [2*DATA_WIDTH-1:0]       i_mul_res,
    input  logic                          i_mul_cry
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           rr_ptr_q;
    logic [IW-1:0]           grant_q;
    logic [CW-1:0]           cnt_q;
    logic [DATA_WIDTH-1:0]   x_q;
    logic [DATA_WIDTH-1:0]   y_q;
    logic [2*DATA_WIDTH-1:0] res_q;
    logic                    cry_q;
    logic                    err_q;

    logic                    w_found;
    logic [IW-1:0]           w_win;
    logic                    w_accept;

    // Index rr_ptr+i wrapped into 0..NUM_REQ-1; i never exceeds NUM_REQ.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_found && i_req_vld[rr_idx(rr_ptr_q, i)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(rr_ptr_q, i);
            end
        end
    end

    assign w_accept    = (state_q == S_IDLE) && w_found && !i_rst;
    assign o_req_rdy   = w_accept ? (NUM_REQ'(1) << w_win) : '0;
    assign o_rsp_vld   = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign o_rsp_res   = res_q;
    assign o_rsp_cry   = cry_q;
    assign o_rsp_err   = err_q;
    assign o_busy      = (state_q != S_IDLE);
    // Multiplier stays out of reset through RESP so its outputs hold still.
    assign o_mul_rst_n = (state_q == S_RUN) || (state_q == S_RESP);
    assign o_mul_num_x = x_q;
    assign o_mul_num_y = y_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= IW'(NUM_REQ - 1);
            grant_q  <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            cry_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        x_q      <= i_req_num_x[w_win*DATA_WIDTH +: DATA_WIDTH];
                        y_q      <= i_req_num_y[w_win*DATA_WIDTH +: DATA_WIDTH];
                        grant_q  <= w_win;
                        rr_ptr_q <= w_win;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    // End takes precedence over a coincident timeout.
                    if (i_mul_end) begin
                        res_q   <= i_mul_res;
                        cry_q   <= i_mul_cry;
                        err_q   <= 1'b0;
                        state_q <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        res_q   <= '0;
                        cry_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (i_rsp_rdy[grant_q]) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_16bit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_16bit_arbiter
// Purpose  : Directed self-checking bench with a behavioural multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_16bit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_vld, req_rdy, rsp_vld, rsp_rdy;
    logic [63:0] req_x, req_y;
    logic [31:0] rsp_res;
    logic        rsp_cry, rsp_err, busy, mul_rst_n;
    logic [15:0] mul_x, mul_y;
    logic        m_end, m_hang;
    logic signed [31:0] m_res;
    logic [7:0]  m_cnt;
    int          m_lat;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mul_16bit_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy),
        .i_req_num_x(req_x), .i_req_num_y(req_y),
        .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy),
        .o_rsp_res(rsp_res), .o_rsp_cry(rsp_cry), .o_rsp_err(rsp_err),
        .o_busy(busy), .o_mul_rst_n(mul_rst_n),
        .o_mul_num_x(mul_x), .o_mul_num_y(mul_y),
        .i_mul_end(m_end), .i_mul_res(m_res), .i_mul_cry(m_res[31])
    );

    // Behavioural multiplier: o_end rises m_lat cycles after reset release.
    always @(posedge clk) begin
        if (!mul_rst_n)         m_cnt <= 8'd0;
        else if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
    end
    assign m_res = $signed(mul_x) * $signed(mul_y);
    assign m_end = mul_rst_n && !m_hang && (int'(m_cnt) >= m_lat);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_vld = '0; rsp_rdy = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (req_rdy == '0 && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) check("rdy_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_vld == '0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("rsp_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input int k, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp, input logic exp_err, input int exp_n);
        int n;
        logic [3:0] oh;
        oh = 4'b0001 << k;
        req_x[k*16 +: 16] = x;
        req_y[k*16 +: 16] = y;
        req_vld = oh;
        #1;
        wait_rdy();
        check("grant", 64'(req_rdy), 64'(oh));
        @(negedge clk);
        req_vld = '0;
        check("load_rst_n", 64'(mul_rst_n), 64'd0);
        check("load_busy", 64'(busy), 64'd1);
        check("load_x", 64'(mul_x), 64'(x));
        wait_rsp(n);
        check("rsp_lat", 64'(n), 64'(exp_n));
        check("rsp_vld", 64'(rsp_vld), 64'(oh));
        check("rsp_res", 64'(rsp_res), 64'(exp));
        check("rsp_cry", 64'(rsp_cry), 64'(exp[31]));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("rsp_rdy_idle", 64'(req_rdy), 64'd0);
        rsp_rdy = oh;
        @(negedge clk);
        rsp_rdy = '0;
        check("post_busy", 64'(busy), 64'd0);
        check("post_vld", 64'(rsp_vld), 64'd0);
    endtask

    initial begin
        int n;
        logic [3:0] exp_oh;
        logic [31:0] rr_exp [4];
        rr_exp[0] = 32'h0000000C; rr_exp[1] = 32'h00010000;
        rr_exp[2] = 32'h00000001; rr_exp[3] = 32'hFFFF0000;
        req_x = '0; req_y = '0; m_hang = 1'b0; m_lat = 3;
        rst = 1'b1; req_vld = '0; rsp_rdy = '0;
        @(negedge clk);
        do_reset();

        check("rst_rdy",   64'(req_rdy), 64'd0);
        check("rst_vld",   64'(rsp_vld), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_mulrn", 64'(mul_rst_n), 64'd0);
        check("rst_res",   64'(rsp_res), 64'd0);
        check("rst_err",   64'(rsp_err), 64'd0);
        check("rst_x",     64'(mul_x), 64'd0);

        run_op(0, 16'hFFFA, 16'hFFF9, 32'h0000002A, 1'b0, 5);
        run_op(2, 16'hFFFA, 16'h0005, 32'hFFFFFFE2, 1'b0, 5);

        // Backpressure on requester 1 with requester 3 waiting.
        req_x[16 +: 16] = 16'd7; req_y[16 +: 16] = 16'd9;
        req_vld = 4'b0010; #1;
        wait_rdy();
        check("bp_grant", 64'(req_rdy), 64'b0010);
        @(negedge clk);
        req_vld = 4'b1000;
        wait_rsp(n);
        rsp_rdy = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_vld", 64'(rsp_vld), 64'b0010);
            check("bp_res", 64'(rsp_res), 64'h3F);
            check("bp_rdy", 64'(req_rdy), 64'd0);
        end
        rsp_rdy = 4'b0010;
        @(negedge clk);
        rsp_rdy = '0;
        check("bp_next_rdy", 64'(req_rdy), 64'b1000);
        req_vld = '0;
        @(negedge clk);
        check("bp_drop_busy", 64'(busy), 64'd0);

        // Hung multiplier then a normal operation.
        m_hang = 1'b1;
        run_op(0, 16'd5, 16'd6, 32'd0, 1'b1, 65);
        m_hang = 1'b0;
        run_op(0, 16'd5, 16'd6, 32'd30, 1'b0, 5);

        // Reset in the middle of RUN.
        m_hang = 1'b1;
        req_vld = 4'b1000; #1;
        wait_rdy();
        @(negedge clk);
        req_vld = '0;
        repeat (5) @(negedge clk);
        check("mid_run", 64'(mul_rst_n), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy",  64'(busy), 64'd0);
        check("mid_vld",   64'(rsp_vld), 64'd0);
        check("mid_mulrn", 64'(mul_rst_n), 64'd0);
        rst = 1'b0;
        req_vld = 4'b1111; #1;
        check("mid_rr", 64'(req_rdy), 64'b0001);
        req_vld = '0;
        m_hang = 1'b0;

        // Round robin with all requesters valid from reset.
        do_reset();
        req_x = {16'h8000, 16'hFFFF, 16'h0100, 16'd3};
        req_y = {16'h0002, 16'hFFFF, 16'h0100, 16'd4};
        req_vld = 4'b1111; rsp_rdy = 4'b1111; #1;
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << (i % 4);
            wait_rdy();
            check("rr_grant", 64'(req_rdy), 64'(exp_oh));
            @(negedge clk);
            wait_rsp(n);
            check("rr_vld", 64'(rsp_vld), 64'(exp_oh));
            check("rr_res", 64'(rsp_res), 64'(rr_exp[i % 4]));
            @(negedge clk); #1;
        end
        req_vld = '0; rsp_rdy = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
